regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file.
- Successor to the single-write, dual-read register file; sits between ID (read side) and MEM/WB (write side).
- Adds configurable read/write port counts, same-cycle write-to-read bypass, and a per-register busy scoreboard for ID hazard detection.
- All state updates on posedge clk; no negedge writes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; REG_NUM = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2); higher index has higher priority.
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = return stored value.

Ports:
- clk  in  1  clock, posedge active.
- rst  in  1  reset: synchronous, active-high.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses; port k in bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  write data, packed the same way.
- rd_addr  in  NUM_RD*ADDR_W  read addresses.
- rd_data  out  NUM_RD*DATA_W  read values, combinational.
- rd_busy  out  NUM_RD  1 = the addressed register has a pending write.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register being issued.
- flush  in  1  clear all busy bits (pipeline flush); register data unaffected.

Behaviour:
- Reset:
  - At a posedge with rst=1: all registers become 0 and all busy bits become 0.
  - wr_en, iss_en and flush are ignored that cycle.
  - While rst=1, rd_data=0 and rd_busy=0 on every port, regardless of address.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - Never busy; iss_addr=0 has no effect.
- Write:
  - At posedge, for each k with wr_en[k]=1 and wr_addr[k]!=0, registers[wr_addr[k]] <= wr_data[k].
  - If two ports target the same address, the higher-index port's data is stored.
- Read:
  - Purely combinational from rd_addr; zero cycles of latency.
  - BYPASS=1: if any enabled write port (address != 0) matches rd_addr, rd_data returns that port's wr_data, using the same priority as writes. Otherwise it returns the stored value.
  - BYPASS=0: stored value only; the new value is visible in the cycle after the edge.
- Scoreboard (one busy bit per register):
  - Set at posedge when iss_en=1 and iss_addr!=0.
  - Cleared at posedge when any wr_en[k]=1 with wr_addr[k] equal to that register.
  - Issue and write to the same register in the same cycle: issue wins, the bit stays/becomes 1, and the data is still written.
  - flush=1 clears all bits at the posedge. An iss_en in the same cycle is still applied after the clear, so that bit ends at 1.
  - rd_busy[j] = busy[rd_addr[j]].
  - BYPASS=1 only: rd_busy[j] is forced to 0 when a same-cycle enabled write hits rd_addr[j]. The data is available on rd_data, so no stall is needed.
- No internal arithmetic; all widths are exact and there is no truncation.
- Reset mid-operation: pending writes and busy state are discarded at the edge. The first write after rst deasserts is accepted in that same cycle.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst for 1 cycle, read r5 -> 0, rd_busy=0; rd_data=0 on all ports while rst=1.
- R0 protect: wr_en[0]=1, wr_addr=0, data 0x1234 -> r0 reads 0; iss_addr=0 -> rd_busy stays 0.
- Bypass:
  - BYPASS=1: write r3=0xA5A5A5A5 while reading r3 in the same cycle -> rd_data=0xA5A5A5A5 that cycle.
  - BYPASS=0: same stimulus -> old value that cycle, 0xA5A5A5A5 the next cycle.
- Write conflict: both ports write r7 in one cycle (port0=0x11, port1=0x22) -> r7=0x22. A same-cycle bypass read of r7 also shows 0x22.
- Scoreboard:
  - Issue r9 -> rd_busy=1 next cycle.
  - Write r9 -> busy cleared after the edge.
  - Issue r9 and write r9 together -> busy remains 1 and r9 holds the new data.
- Flush: issue r4, r6 -> flush with simultaneous issue r8 -> r4, r6 not busy, r8 busy; register contents unchanged.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: write ports, read ports, issue and flush.
// master drives writes/reads/issue/flush; slave returns rd_data/rd_busy.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr, iss_en, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, iss_en, iss_addr, flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);
  localparam int REG_NUM = 2**ADDR_W;

  logic [DATA_W-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_nxt;

  logic [ADDR_W-1:0]  w_wa [NUM_WR];
  logic [DATA_W-1:0]  w_wd [NUM_WR];
  logic [NUM_WR-1:0]  w_we;

  // w_we excludes r0 so every consumer sees writes to r0 as absent
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_wa[k] = bus.wr_addr[k*ADDR_W +: ADDR_W];
    assign w_wd[k] = bus.wr_data[k*DATA_W +: DATA_W];
    assign w_we[k] = bus.wr_en[k] && (w_wa[k] != '0);
  end

  // Ordering: writes clear, flush clears all, issue sets last.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NUM_WR; k++)
      if (w_we[k]) w_busy_nxt[w_wa[k]] = 1'b0;
    if (bus.flush) w_busy_nxt = '0;
    if (bus.iss_en) w_busy_nxt[bus.iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Later ports overwrite earlier ones: highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++)
        r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (w_we[k]) r_regs[w_wa[k]] <= w_wd[k];
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_d;
    logic              w_b;

    assign w_ra = bus.rd_addr[j*ADDR_W +: ADDR_W];

    always_comb begin
      w_d = r_regs[w_ra];
      w_b = r_busy[w_ra];
      // Bypassed data needs no stall, so busy drops.
      if (BYPASS != 0)
        for (int k = 0; k < NUM_WR; k++)
          if (w_we[k] && (w_wa[k] == w_ra)) begin
            w_d = w_wd[k];
            w_b = 1'b0;
          end
      if (rst || (w_ra == '0)) begin
        w_d = '0;
        w_b = 1'b0;
      end
    end

    assign bus.rd_data[j*DATA_W +: DATA_W] = w_d;
    assign bus.rd_busy[j] = w_b;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one BYPASS=1 and one BYPASS=0
// instance driven identically, checked against a behavioural model.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst;
  logic [1:0]  t_we;
  logic [4:0]  t_wa [2];
  logic [31:0] t_wd [2];
  logic [4:0]  t_ra [2];
  logic        t_iss;
  logic [4:0]  t_ia;
  logic        t_fl;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) b1 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) b0 ();

  assign b1.wr_en    = t_we;
  assign b1.wr_addr  = {t_wa[1], t_wa[0]};
  assign b1.wr_data  = {t_wd[1], t_wd[0]};
  assign b1.rd_addr  = {t_ra[1], t_ra[0]};
  assign b1.iss_en   = t_iss;
  assign b1.iss_addr = t_ia;
  assign b1.flush    = t_fl;
  assign b0.wr_en    = t_we;
  assign b0.wr_addr  = {t_wa[1], t_wa[0]};
  assign b0.wr_data  = {t_wd[1], t_wd[0]};
  assign b0.rd_addr  = {t_ra[1], t_ra[0]};
  assign b0.iss_en   = t_iss;
  assign b0.iss_addr = t_ia;
  assign b0.flush    = t_fl;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
               .BYPASS(1)) u_dut1 (
    .clk(clk), .rst(t_rst), .bus(b1));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
               .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(t_rst), .bus(b0));

  // Model: what a read port should show right now.
  function automatic logic [31:0] exp_data(int j, bit byp);
    logic [4:0] a;
    a = t_ra[j];
    if (t_rst || a == 0) return 32'h0;
    if (byp)
      for (int k = 1; k >= 0; k--)
        if (t_we[k] && t_wa[k] == a) return t_wd[k];
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int j, bit byp);
    logic [4:0] a;
    a = t_ra[j];
    if (t_rst || a == 0) return 1'b0;
    if (byp)
      for (int k = 0; k < 2; k++)
        if (t_we[k] && t_wa[k] == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void commit();
    if (t_rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (t_we[k] && t_wa[k] != 0) m_regs[t_wa[k]] = t_wd[k];
      for (int k = 0; k < 2; k++)
        if (t_we[k]) m_busy[t_wa[k]] = 1'b0;
      if (t_fl)
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (t_iss && t_ia != 0) m_busy[t_ia] = 1'b1;
    end
  endfunction

  task automatic idle();
    t_rst = 1'b0;
    t_we = 2'b00;
    t_wa[0] = 0; t_wa[1] = 0;
    t_wd[0] = 0; t_wd[1] = 0;
    t_ra[0] = 0; t_ra[1] = 0;
    t_iss = 1'b0; t_ia = 0; t_fl = 1'b0;
  endtask

  // Inputs change at negedge; DUT and model both update at posedge.
  task automatic tick();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    t_we = 2'b01; t_wa[0] = 5; t_wd[0] = 32'hDEADBEEF; t_ra[0] = 5;
    #1;
    n_tot++;
    if (b1.rd_data[31:0] !== 32'hDEADBEEF)
      $display("FAIL rst_byp_wr got=%h exp=DEADBEEF", b1.rd_data[31:0]);
    else n_pass++;
    tick();
    idle(); t_ra[0] = 5;
    #1;
    n_tot++;
    if (b0.rd_data[31:0] !== 32'hDEADBEEF)
      $display("FAIL rst_stored got=%h exp=DEADBEEF", b0.rd_data[31:0]);
    else n_pass++;
    t_rst = 1'b1; t_ra[1] = 5;
    t_we = 2'b10; t_wa[1] = 5; t_wd[1] = 32'h55;
    t_iss = 1'b1; t_ia = 5;
    #1;
    n_tot++;
    if (b1.rd_data !== 64'h0)
      $display("FAIL rst_rd_zero1 got=%h exp=0", b1.rd_data);
    else n_pass++;
    n_tot++;
    if (b0.rd_data !== 64'h0 || b1.rd_busy !== 2'b00)
      $display("FAIL rst_rd_zero0 got=%h/%b exp=0/00",
               b0.rd_data, b1.rd_busy);
    else n_pass++;
    tick();
    idle();
    t_we = 2'b01; t_wa[0] = 6; t_wd[0] = 32'h77;
    t_ra[0] = 5; t_ra[1] = 5;
    #1;
    n_tot++;
    if (b0.rd_data[31:0] !== 32'h0)
      $display("FAIL rst_cleared got=%h exp=0", b0.rd_data[31:0]);
    else n_pass++;
    n_tot++;
    if (b0.rd_busy !== 2'b00)
      $display("FAIL rst_iss_ignored got=%b exp=00", b0.rd_busy);
    else n_pass++;
    tick();
    idle(); t_ra[1] = 6;
    #1;
    n_tot++;
    if (b0.rd_data[63:32] !== 32'h77)
      $display("FAIL rst_first_wr got=%h exp=77", b0.rd_data[63:32]);
    else n_pass++;
  endtask

  task automatic test_r0();
    idle();
    t_we = 2'b01; t_wa[0] = 0; t_wd[0] = 32'h1234;
    t_iss = 1'b1; t_ia = 0;
    #1;
    n_tot++;
    if (b1.rd_data[31:0] !== 32'h0)
      $display("FAIL r0_byp got=%h exp=0", b1.rd_data[31:0]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_tot++;
    if (b0.rd_data[31:0] !== 32'h0 || b1.rd_data[31:0] !== 32'h0)
      $display("FAIL r0_read got=%h/%h exp=0",
               b0.rd_data[31:0], b1.rd_data[31:0]);
    else n_pass++;
    n_tot++;
    if (b0.rd_busy[0] !== 1'b0)
      $display("FAIL r0_busy got=%b exp=0", b0.rd_busy[0]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    idle();
    t_we = 2'b01; t_wa[0] = 3; t_wd[0] = 32'h1;
    tick();
    idle();
    t_we = 2'b10; t_wa[1] = 3; t_wd[1] = 32'hA5A5A5A5; t_ra[0] = 3;
    #1;
    n_tot++;
    if (b1.rd_data[31:0] !== 32'hA5A5A5A5)
      $display("FAIL byp1_same got=%h exp=A5A5A5A5", b1.rd_data[31:0]);
    else n_pass++;
    n_tot++;
    if (b0.rd_data[31:0] !== 32'h1)
      $display("FAIL byp0_old got=%h exp=1", b0.rd_data[31:0]);
    else n_pass++;
    tick();
    idle(); t_ra[0] = 3;
    #1;
    n_tot++;
    if (b0.rd_data[31:0] !== 32'hA5A5A5A5)
      $display("FAIL byp0_next got=%h exp=A5A5A5A5", b0.rd_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_conflict();
    idle();
    t_we = 2'b11;
    t_wa[0] = 7; t_wd[0] = 32'h11;
    t_wa[1] = 7; t_wd[1] = 32'h22;
    t_ra[0] = 7; t_ra[1] = 7;
    #1;
    n_tot++;
    if (b1.rd_data !== {32'h22, 32'h22})
      $display("FAIL conf_byp got=%h exp=22/22", b1.rd_data);
    else n_pass++;
    tick();
    idle(); t_ra[1] = 7;
    #1;
    n_tot++;
    if (b0.rd_data[63:32] !== 32'h22)
      $display("FAIL conf_store got=%h exp=22", b0.rd_data[63:32]);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle();
    t_iss = 1'b1; t_ia = 9; t_ra[0] = 9;
    #1;
    n_tot++;
    if (b0.rd_busy[0] !== 1'b0)
      $display("FAIL sb_pre got=%b exp=0", b0.rd_busy[0]);
    else n_pass++;
    tick();
    idle(); t_ra[0] = 9; t_ra[1] = 9;
    #1;
    n_tot++;
    if (b0.rd_busy !== 2'b11 || b1.rd_busy !== 2'b11)
      $display("FAIL sb_set got=%b/%b exp=11", b0.rd_busy, b1.rd_busy);
    else n_pass++;
    t_we = 2'b01; t_wa[0] = 9; t_wd[0] = 32'h90;
    #1;
    n_tot++;
    if (b1.rd_busy[0] !== 1'b0 || b0.rd_busy[0] !== 1'b1)
      $display("FAIL sb_byp_busy got=%b/%b exp=0/1",
               b1.rd_busy[0], b0.rd_busy[0]);
    else n_pass++;
    tick();
    idle(); t_ra[0] = 9;
    #1;
    n_tot++;
    if (b0.rd_busy[0] !== 1'b0)
      $display("FAIL sb_clr got=%b exp=0", b0.rd_busy[0]);
    else n_pass++;
    t_iss = 1'b1; t_ia = 9;
    t_we = 2'b10; t_wa[1] = 9; t_wd[1] = 32'h99;
    tick();
    idle(); t_ra[0] = 9;
    #1;
    n_tot++;
    if (b0.rd_busy[0] !== 1'b1 || b0.rd_data[31:0] !== 32'h99)
      $display("FAIL sb_iss_wr got=%b/%h exp=1/99",
               b0.rd_busy[0], b0.rd_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_flush();
    idle(); t_iss = 1'b1; t_ia = 4;
    tick();
    idle(); t_iss = 1'b1; t_ia = 6;
    tick();
    idle(); t_fl = 1'b1; t_iss = 1'b1; t_ia = 8;
    tick();
    idle(); t_ra[0] = 4; t_ra[1] = 6;
    #1;
    n_tot++;
    if (b0.rd_busy !== 2'b00)
      $display("FAIL fl_clr got=%b exp=00", b0.rd_busy);
    else n_pass++;
    t_ra[0] = 8; t_ra[1] = 9;
    #1;
    n_tot++;
    if (b0.rd_busy !== 2'b01)
      $display("FAIL fl_iss got=%b exp=01", b0.rd_busy);
    else n_pass++;
    t_ra[0] = 7;
    #1;
    n_tot++;
    if (b0.rd_data !== {32'h99, 32'h22})
      $display("FAIL fl_data got=%h exp=99/22", b0.rd_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      t_rst = ($urandom_range(0, 39) == 0);
      t_we = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        t_wa[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                              : 5'($urandom_range(0, 7));
        t_wd[k] = $urandom;
        t_ra[k] = 5'($urandom_range(0, 7));
      end
      t_iss = ($urandom_range(0, 2) == 0);
      t_ia = 5'($urandom_range(0, 7));
      t_fl = ($urandom_range(0, 15) == 0);
      #1;
      for (int j = 0; j < 2; j++) begin
        logic [31:0] e1, e0;
        bit          f1, f0;
        e1 = exp_data(j, 1'b1);
        e0 = exp_data(j, 1'b0);
        f1 = exp_busy(j, 1'b1);
        f0 = exp_busy(j, 1'b0);
        n_tot++;
        if (b1.rd_data[j*32 +: 32] !== e1)
          $display("FAIL rnd_data1 c=%0d p=%0d got=%h exp=%h",
                   c, j, b1.rd_data[j*32 +: 32], e1);
        else n_pass++;
        n_tot++;
        if (b0.rd_data[j*32 +: 32] !== e0)
          $display("FAIL rnd_data0 c=%0d p=%0d got=%h exp=%h",
                   c, j, b0.rd_data[j*32 +: 32], e0);
        else n_pass++;
        n_tot++;
        if (b1.rd_busy[j] !== f1 || b0.rd_busy[j] !== f0)
          $display("FAIL rnd_busy c=%0d p=%0d got=%b/%b exp=%b/%b",
                   c, j, b1.rd_busy[j], b0.rd_busy[j], f1, f0);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    idle();
    t_rst = 1'b1;
    @(negedge clk);
    tick();
    test_reset();
    test_r0();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
